// File: rtl/toggle_pkg.sv
// rtl/toggle_pkg.sv - shared mode encodings and helpers for toggle_counter
//
// Purpose:
//   Holds the operation-select encoding used by toggle_counter and any
//   consumer that drives its mode input, so both sides agree on one set
//   of names instead of bare 2-bit literals.
//
// Contents:
//   mode_e         2-bit operation select (TOGGLE/UP/DOWN/HOLD)
//   MODE_W         width of the mode field
//   WIDTH_MIN/MAX  legal range of the counter width parameter
//   is_counting()  true for the modes that can produce a limit event

package toggle_pkg;

  localparam int MODE_W    = 2;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [MODE_W-1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // UP and DOWN are the only modes that can hit a limit (tc/ovf source).
  function automatic logic is_counting(input mode_e m);
    return (m == MODE_UP) || (m == MODE_DOWN);
  endfunction

endpackage

// File: rtl/tff_bit.sv
// rtl/tff_bit.sv - single T flip-flop with async reset value and sync load
//
// Purpose:
//   One bit of toggle_counter state. The parent decides, per bit and per
//   cycle, whether this bit toggles; this cell only stores it.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   rst_val   in   value forced onto q while rst is low (tie to a constant)
//   load      in   synchronous load strobe, overrides t
//   load_val  in   value taken on load
//   t         in   toggle enable for this edge
//   q         out  stored bit

module tff_bit
  import toggle_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic load,
  input  logic load_val,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= rst_val;
    end else if (load) begin
      q <= load_val;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/toggle_counter.sv
// rtl/toggle_counter.sv - T flip-flop register usable as toggle mask, up or down counter
//
// Purpose:
//   WIDTH-bit register built from tff_bit cells. Every operation, including
//   counting, is expressed as a per-bit toggle mask computed here; the cells
//   only ever toggle, load or reset.
//
// Parameters:
//   WIDTH     register width, 2..32
//   RST_VAL   value of q while reset is asserted
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   en        in   operation enable
//   mode      in   00 TOGGLE, 01 UP, 10 DOWN, 11 HOLD (toggle_pkg::mode_e)
//   t         in   per-bit toggle mask (TOGGLE mode)
//   sat       in   0 wrap / 1 saturate at limits (UP/DOWN)
//   load      in   synchronous load strobe, highest priority
//   load_val  in   value written on load
//   ovf_clr   in   clears sticky ovf (a coincident limit event wins)
//   q         out  registered state
//   tc        out  registered terminal-count, high the cycle after a limit event
//   ovf       out  registered sticky overflow/underflow flag

module toggle_counter
  import toggle_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  mode_e            mode_sel;
  logic [WIDTH-1:0] up_mask;
  logic [WIDTH-1:0] dn_mask;
  logic [WIDTH-1:0] next_mask;
  logic             at_max;
  logic             at_zero;
  logic             limit;

  assign mode_sel = mode_e'(mode);
  assign at_max   = &q;
  assign at_zero  = ~|q;

  // Ripple-style toggle masks: counting up, bit i flips when every lower
  // bit is 1; counting down, when every lower bit is 0. At all-ones (up) or
  // zero (down) the mask is all ones, which is exactly the wrap value.
  always_comb begin : mask_gen
    logic carry_up;
    logic carry_dn;
    up_mask  = '0;
    dn_mask  = '0;
    carry_up = 1'b1;
    carry_dn = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_mask[i] = carry_up;
      dn_mask[i] = carry_dn;
      carry_up   = carry_up & q[i];
      carry_dn   = carry_dn & ~q[i];
    end
  end

  // Per-edge action. Saturation is just an all-zero mask at the limit.
  // load is not considered here: the cells give it priority over t, and
  // the status flops below mask limit with load.
  always_comb begin
    next_mask = '0;
    limit     = 1'b0;
    if (en) begin
      case (mode_sel)
        MODE_TOGGLE: next_mask = t;
        MODE_UP: begin
          limit     = at_max;
          next_mask = (at_max && sat) ? '0 : up_mask;
        end
        MODE_DOWN: begin
          limit     = at_zero;
          next_mask = (at_zero && sat) ? '0 : dn_mask;
        end
        default: next_mask = '0;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_bit u_bit (
      .clk      (clk),
      .rst      (rst),
      .rst_val  (RST_VAL[i]),
      .load     (load),
      .load_val (load_val[i]),
      .t        (next_mask[i]),
      .q        (q[i])
    );
  end

  // tc is a pure function of this edge's limit event, so back-to-back
  // saturated limits hold it high. ovf set beats ovf_clr on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      tc <= limit && !load;
      if (limit && !load) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_counter.sv
// tb/tb_toggle_counter.sv - self-checking bench for toggle_counter (WIDTH=4)

module tb_toggle_counter;

  localparam int W   = 4;
  localparam int LIM = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] t;
  logic         sat;
  logic         load;
  logic [W-1:0] load_val;
  logic         ovf_clr;
  logic [W-1:0] q;
  logic         tc;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  int mq;
  bit mtc;
  bit mov;

  toggle_counter #(.WIDTH(W), .RST_VAL(4'd0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .t        (t),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .ovf_clr  (ovf_clr),
    .q        (q),
    .tc       (tc),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit limit;
    limit = 1'b0;
    if (!rst) begin
      mq = 0; mtc = 0; mov = 0;
      return;
    end
    if (load) begin
      mq  = int'(load_val);
      mtc = 0;
      if (ovf_clr) mov = 0;
      return;
    end
    if (en && mode == 2'd1) begin
      if (mq == LIM) begin limit = 1; if (!sat) mq = 0; end
      else mq = mq + 1;
    end else if (en && mode == 2'd2) begin
      if (mq == 0) begin limit = 1; if (!sat) mq = LIM; end
      else mq = mq - 1;
    end else if (en && mode == 2'd0) begin
      mq = mq ^ int'(t);
    end
    mtc = limit;
    if (limit) mov = 1;
    else if (ovf_clr) mov = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 0; mode = 2'd3; t = '0; sat = 0; load = 0; load_val = '0; ovf_clr = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    mq = 0; mtc = 0; mov = 0;
    #1;
    checks++; if (q !== 4'd0) begin failures++; $display("FAIL reset_q got=%0d exp=0", q); end
    checks++; if (tc !== 1'b0) begin failures++; $display("FAIL reset_tc got=%b exp=0", tc); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    load = 1; load_val = 4'd9; en = 1; mode = 2'd1;
    tick(); tick();
    checks++; if (q !== 4'd0) begin failures++; $display("FAIL reset_ignores_inputs got=%0d exp=0", q); end
    idle();
    rst = 1;
  endtask

  task automatic test_toggle();
    idle(); en = 1; mode = 2'd0; t = 4'b0101;
    tick();
    checks++; if (q !== 4'b0101) begin failures++; $display("FAIL toggle_q1 got=%b exp=0101", q); end
    checks++; if (tc !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL toggle_flags1 got tc=%b ovf=%b exp 0 0", tc, ovf); end
    tick();
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL toggle_q2 got=%b exp=0000", q); end
    checks++; if (tc !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL toggle_flags2 got tc=%b ovf=%b exp 0 0", tc, ovf); end
  endtask

  task automatic test_up_wrap();
    idle(); load = 1; load_val = 4'b1110;
    tick();
    checks++; if (q !== 4'b1110) begin failures++; $display("FAIL up_load got=%b exp=1110", q); end
    load = 0; en = 1; mode = 2'd1; sat = 0;
    tick();
    checks++; if (q !== 4'b1111 || tc !== 1'b0) begin failures++; $display("FAIL up_step got q=%b tc=%b exp 1111 0", q, tc); end
    tick();
    checks++; if (q !== 4'b0000) begin failures++; $display("FAIL up_wrap_q got=%b exp=0000", q); end
    checks++; if (tc !== 1'b1 || ovf !== 1'b1) begin failures++; $display("FAIL up_wrap_flags got tc=%b ovf=%b exp 1 1", tc, ovf); end
    idle();
    tick();
    checks++; if (tc !== 1'b0 || ovf !== 1'b1 || q !== 4'd0) begin failures++; $display("FAIL up_tc_one_cycle got q=%0d tc=%b ovf=%b exp 0 0 1", q, tc, ovf); end
  endtask

  task automatic test_down_sat();
    idle(); ovf_clr = 1;
    tick();
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", ovf); end
    ovf_clr = 0; load = 1; load_val = 4'b0001;
    tick();
    load = 0; en = 1; mode = 2'd2; sat = 1;
    tick();
    checks++; if (q !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL down_sat1 got q=%0d tc=%b ovf=%b exp 0 0 0", q, tc, ovf); end
    tick();
    checks++; if (q !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1) begin failures++; $display("FAIL down_sat2 got q=%0d tc=%b ovf=%b exp 0 1 1", q, tc, ovf); end
    tick();
    checks++; if (q !== 4'd0 || tc !== 1'b1 || ovf !== 1'b1) begin failures++; $display("FAIL down_sat3 got q=%0d tc=%b ovf=%b exp 0 1 1", q, tc, ovf); end
  endtask

  task automatic test_ovf_race();
    idle(); load = 1; load_val = 4'b1111;
    tick();
    checks++; if (ovf !== 1'b1 || tc !== 1'b0) begin failures++; $display("FAIL load_keeps_ovf got tc=%b ovf=%b exp 0 1", tc, ovf); end
    load = 0; en = 1; mode = 2'd1; sat = 0; ovf_clr = 1;
    tick();
    checks++; if (ovf !== 1'b1 || tc !== 1'b1 || q !== 4'd0) begin failures++; $display("FAIL race_limit_wins got q=%0d tc=%b ovf=%b exp 0 1 1", q, tc, ovf); end
    en = 0;
    tick();
    checks++; if (ovf !== 1'b0 || tc !== 1'b0) begin failures++; $display("FAIL race_clear_after got tc=%b ovf=%b exp 0 0", tc, ovf); end
  endtask

  task automatic test_load_priority();
    idle(); load = 1; en = 1; mode = 2'd1; load_val = 4'b0111;
    tick();
    checks++; if (q !== 4'b0111 || tc !== 1'b0) begin failures++; $display("FAIL load_priority got q=%b tc=%b exp 0111 0", q, tc); end
    load = 0; en = 0;
    tick();
    checks++; if (q !== 4'b0111 || tc !== 1'b0) begin failures++; $display("FAIL load_then_hold got q=%b tc=%b exp 0111 0", q, tc); end
  endtask

  task automatic test_async_reset();
    idle(); load = 1; load_val = 4'hF;
    tick();
    load = 0; en = 1; mode = 2'd1; sat = 1;
    tick();
    load = 1; load_val = 4'd9; en = 0;
    tick();
    checks++; if (q !== 4'd9 || ovf !== 1'b1) begin failures++; $display("FAIL pre_reset got q=%0d ovf=%b exp 9 1", q, ovf); end
    idle();
    #2;
    rst = 0;
    mq = 0; mtc = 0; mov = 0;
    #1;
    checks++; if (q !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL async_reset got q=%0d tc=%b ovf=%b exp 0 0 0", q, tc, ovf); end
    en = 1; mode = 2'd1;
    tick();
    checks++; if (q !== 4'd0) begin failures++; $display("FAIL reset_held got=%0d exp=0", q); end
    rst = 1;
    tick();
    checks++; if (q !== 4'd1) begin failures++; $display("FAIL first_after_release got=%0d exp=1", q); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        idle();
        rst = 0;
        mq = 0; mtc = 0; mov = 0;
        #1;
        checks++; if (q !== 4'd0 || tc !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL rand_async_reset n=%0d got q=%0d tc=%b ovf=%b exp 0 0 0", n, q, tc, ovf); end
        tick();
        rst = 1;
      end
      en       = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom_range(0, 3));
      t        = 4'($urandom);
      sat      = 1'($urandom);
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom);
      ovf_clr  = ($urandom_range(0, 7) == 0);
      tick();
      checks++; if (q !== mq[W-1:0]) begin failures++; $display("FAIL rand_q n=%0d got=%0d exp=%0d", n, q, mq); end
      checks++; if (tc !== mtc) begin failures++; $display("FAIL rand_tc n=%0d got=%b exp=%b", n, tc, mtc); end
      checks++; if (ovf !== mov) begin failures++; $display("FAIL rand_ovf n=%0d got=%b exp=%b", n, ovf, mov); end
    end
  endtask

  initial begin
    test_reset();
    test_toggle();
    test_up_wrap();
    test_down_sat();
    test_ovf_race();
    test_load_priority();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
